// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// The state encoding, table geometry and a popcount helper are used by the sequencer and by reporting code.
package cello_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  localparam int NUM_COMBOS = 8;
  localparam int IDX_W      = 3;

  function automatic logic [3:0] popcount8(input logic [7:0] value);
    logic [3:0] total;
    total = 4'd0;
    for (int i = 0; i < 8; i++) begin
      total = total + {3'd0, value[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Host-side bundle of the sweeper: the sweep request, the expected code and the reported results.
interface truth_table_sweeper_if;
  import cello_sweep_pkg::*;

  logic                  start;
  logic                  abort;
  logic [NUM_COMBOS-1:0] expected;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [NUM_COMBOS-1:0] observed;
  logic [NUM_COMBOS-1:0] mismatch;

  modport master (
    output start, abort, expected,
    input  busy, done, pass, observed, mismatch
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, pass, observed, mismatch
  );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle counter: clear has priority over enable.
// tc flags the last settle cycle of the current input combination.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_r;

  // Counts settle cycles for the combination currently driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign tc = (count_r == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input gate through all eight input combinations, records its output per row,
// and reports the observed table against a latched expected code.
module truth_table_sweeper
  import cello_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  host,
  output logic                  gate_in1,
  output logic                  gate_in2,
  output logic                  gate_in3,
  input  logic                  gate_out
);

  sweep_state_e          state_r;
  logic [IDX_W-1:0]      idx_r;
  logic [NUM_COMBOS-1:0] work_r;
  logic [NUM_COMBOS-1:0] exp_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  pass_r;
  logic [NUM_COMBOS-1:0] observed_r;
  logic [NUM_COMBOS-1:0] mismatch_r;

  logic [NUM_COMBOS-1:0] sampled_s;
  logic                  settle_tc_s;
  logic                  timer_clr_s;
  logic                  timer_en_s;

  // Working table with the row being sampled already filled in, so DONE entry sees all eight rows.
  always_comb begin
    sampled_s         = work_r;
    sampled_s[idx_r]  = gate_out;
  end

  // The timer runs only while settling and restarts for every new combination.
  always_comb begin
    timer_en_s  = (state_r == SETTLE);
    timer_clr_s = (state_r != SETTLE) || host.abort;
  end

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr_s),
    .en  (timer_en_s),
    .tc  (settle_tc_s)
  );

  // Sweep sequencer; result registers move only on DONE entry so an abort leaves them intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= {IDX_W{1'b0}};
      work_r     <= {NUM_COMBOS{1'b0}};
      exp_r      <= {NUM_COMBOS{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      observed_r <= {NUM_COMBOS{1'b0}};
      mismatch_r <= {NUM_COMBOS{1'b0}};
    end else begin
      done_r <= 1'b0;
      if (host.abort && (state_r != IDLE)) begin
        state_r <= IDLE;
        idx_r   <= {IDX_W{1'b0}};
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (host.start && !host.abort) begin
              exp_r   <= host.expected;
              work_r  <= {NUM_COMBOS{1'b0}};
              idx_r   <= {IDX_W{1'b0}};
              busy_r  <= 1'b1;
              state_r <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_tc_s) begin
              state_r <= SAMPLE;
            end
          end
          SAMPLE: begin
            work_r <= sampled_s;
            if (idx_r != IDX_W'(NUM_COMBOS - 1)) begin
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= SETTLE;
            end else begin
              observed_r <= sampled_s;
              mismatch_r <= sampled_s ^ exp_r;
              pass_r     <= (sampled_s == exp_r);
              done_r     <= 1'b1;
              busy_r     <= 1'b0;
              state_r    <= DONE;
            end
          end
          DONE: begin
            idx_r   <= {IDX_W{1'b0}};
            state_r <= IDLE;
          end
          default: begin
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign gate_in1      = idx_r[2];
  assign gate_in2      = idx_r[1];
  assign gate_in3      = idx_r[0];
  assign host.busy     = busy_r;
  assign host.done     = done_r;
  assign host.pass     = pass_r;
  assign host.observed = observed_r;
  assign host.mismatch = mismatch_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised scoreboard bench for truth_table_sweeper with an edge-level reference model.
module tb_truth_table_sweeper;
  import cello_sweep_pkg::*;

  localparam int S_A     = 4;
  localparam int S_B     = 1;
  localparam int SWEEP_A = 8 * (S_A + 1);
  localparam int SWEEP_B = 8 * (S_B + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_sweeper_if a_if ();
  truth_table_sweeper_if b_if ();

  logic       a_g1, a_g2, a_g3, a_gout;
  logic       b_g1, b_g2, b_g3, b_gout;
  logic [7:0] gate_tbl_a;

  assign a_gout = gate_tbl_a[{a_g1, a_g2, a_g3}];
  assign b_gout = 1'b1;

  truth_table_sweeper #(.SETTLE_CYCLES(S_A), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .host(a_if.slave),
    .gate_in1(a_g1), .gate_in2(a_g2), .gate_in3(a_g3), .gate_out(a_gout)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(S_B), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .host(b_if.slave),
    .gate_in1(b_g1), .gate_in2(b_g2), .gate_in3(b_g3), .gate_out(b_gout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         done_edge;
    logic [7:0] obs;
    logic [7:0] exp_v;
  } sweep_rec_t;

  sweep_rec_t sb_q[$];
  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model state, in units of clock edges.
  bit m_pending  = 1'b0;
  int m_e0       = 0;
  int m_done     = 0;
  int m_free     = 0;
  int m_rst_edge = -1;

  function automatic logic [7:0] and_or_table();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      bit in1, in2, in3;
      in1  = ((i / 4) % 2) == 1;
      in2  = ((i / 2) % 2) == 1;
      in3  = (i % 2) == 1;
      t[i] = in3 & (in1 | in2);
    end
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp_v, cyc);
    end
  endtask

  // One host cycle: drive at the falling edge, then predict what the next rising edge does.
  task automatic drive(input bit st, input bit ab, input bit rs, input logic [7:0] ev);
    int e;
    @(negedge clk);
    a_if.start    = st;
    a_if.abort    = ab;
    a_if.expected = ev;
    rst           = rs;
    e = cyc + 1;
    if (rs) begin
      if (m_pending && e <= m_done) sb_q.delete(sb_q.size() - 1);
      m_pending  = 1'b0;
      m_free     = e + 1;
      m_rst_edge = e;
    end else if (ab && m_pending && e <= m_done) begin
      sb_q.delete(sb_q.size() - 1);
      m_pending = 1'b0;
      m_free    = e + 1;
    end else if (st && !ab && e >= m_free) begin
      sweep_rec_t rec;
      m_pending     = 1'b1;
      m_e0          = e;
      m_done        = e + SWEEP_A;
      m_free        = m_done + 2;
      rec.done_edge = m_done;
      rec.obs       = gate_tbl_a;
      rec.exp_v     = ev;
      sb_q.push_back(rec);
    end
  endtask

  task automatic idle_until(input int target);
    while (cyc + 1 < target) drive(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc + 1 < m_free && n < 200) begin
      drive(1'b0, 1'b0, 1'b0, 8'($urandom));
      n++;
    end
    check("wait_idle_bound", 32'(n < 200), 32'd1);
  endtask

  // Monitor: pops the scoreboard on done and tracks result, busy and gate-drive expectations.
  initial begin
    sweep_rec_t rec;
    logic [7:0] r_obs;
    logic [7:0] r_mm;
    logic       r_pass;
    r_obs  = 8'h00;
    r_mm   = 8'h00;
    r_pass = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (cyc == m_rst_edge) begin
          r_obs  = 8'h00;
          r_mm   = 8'h00;
          r_pass = 1'b0;
        end
        if (sb_q.size() > 0 && (a_if.done === 1'b1 || cyc >= sb_q[0].done_edge)) begin
          rec = sb_q.pop_front();
          check("done_edge", (a_if.done === 1'b1) ? 32'(cyc) : 32'hFFFF_FFFF, 32'(rec.done_edge));
          r_obs  = rec.obs;
          r_mm   = rec.obs ^ rec.exp_v;
          r_pass = (rec.obs == rec.exp_v);
        end else if (sb_q.size() == 0) begin
          check("spurious_done", {31'd0, a_if.done}, 32'd0);
        end
        check("observed", {24'd0, a_if.observed}, {24'd0, r_obs});
        check("mismatch", {24'd0, a_if.mismatch}, {24'd0, r_mm});
        check("pass", {31'd0, a_if.pass}, {31'd0, r_pass});
        check("busy", {31'd0, a_if.busy}, 32'(m_pending && cyc >= m_e0 && cyc < m_done));
        if (m_pending && cyc >= m_e0 && cyc < m_done)
          check("gate_in", {29'd0, a_g1, a_g2, a_g3}, 32'((cyc - m_e0) / (S_A + 1)));
        else if (!m_pending)
          check("gate_in_idle", {29'd0, a_g1, a_g2, a_g3}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int b_e0;
    int b_done_cyc;
    rst           = 1'b1;
    a_if.start    = 1'b0;
    a_if.abort    = 1'b0;
    a_if.expected = 8'h00;
    b_if.start    = 1'b0;
    b_if.abort    = 1'b0;
    b_if.expected = 8'h00;
    gate_tbl_a    = and_or_table();

    drive(1'b0, 1'b0, 1'b1, 8'h00);
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Short settle, constant-1 gate on the second instance.
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    b_if.start    = 1'b1;
    b_if.expected = 8'hFF;
    b_e0          = cyc + 1;
    b_done_cyc    = -1;
    for (int i = 0; i < SWEEP_B + 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      b_if.start = 1'b0;
      if (b_if.done === 1'b1 && b_done_cyc < 0) b_done_cyc = cyc;
      if (b_if.busy === 1'b1)
        check("b_gate_in", {29'd0, b_g1, b_g2, b_g3}, 32'((cyc - b_e0) / (S_B + 1)));
    end
    check("b_done_edge", 32'(b_done_cyc), 32'(b_e0 + SWEEP_B));
    check("b_pass", {31'd0, b_if.pass}, 32'd1);
    check("b_observed", {24'd0, b_if.observed}, 32'h0000_00FF);
    check("b_mismatch", {24'd0, b_if.mismatch}, 32'd0);

    // Matching expected code.
    drive(1'b1, 1'b0, 1'b0, 8'hA8);
    wait_idle();
    check("t1_observed", {24'd0, a_if.observed}, 32'h0000_00A8);
    check("t1_pass", {31'd0, a_if.pass}, 32'd1);
    check("t1_mismatch", {24'd0, a_if.mismatch}, 32'd0);

    // Wrong expected code.
    drive(1'b1, 1'b0, 1'b0, 8'h80);
    wait_idle();
    check("t2_observed", {24'd0, a_if.observed}, 32'h0000_00A8);
    check("t2_pass", {31'd0, a_if.pass}, 32'd0);
    check("t2_mismatch", {24'd0, a_if.mismatch}, 32'h0000_0028);

    // Abort while settling row 5.
    drive(1'b1, 1'b0, 1'b0, 8'hFF);
    e0 = m_e0;
    idle_until(e0 + 5 * (S_A + 1) + 2);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t3_busy", {31'd0, a_if.busy}, 32'd0);
    check("t3_gate_in", {29'd0, a_g1, a_g2, a_g3}, 32'd0);
    check("t3_observed", {24'd0, a_if.observed}, 32'h0000_00A8);
    check("t3_pass", {31'd0, a_if.pass}, 32'd0);
    wait_idle();

    // Starts while busy and during DONE are dropped; the following start runs.
    drive(1'b1, 1'b0, 1'b0, 8'hA8);
    e0 = m_e0;
    idle_until(e0 + 10);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    idle_until(e0 + SWEEP_A + 1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'hA8);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t4_restart_busy", {31'd0, a_if.busy}, 32'd1);
    check("t4_pass", {31'd0, a_if.pass}, 32'd1);
    wait_idle();

    // Reset together with abort and start mid-sweep.
    drive(1'b1, 1'b0, 1'b0, 8'hA8);
    e0 = m_e0;
    idle_until(e0 + 17);
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t5_observed", {24'd0, a_if.observed}, 32'd0);
    check("t5_pass", {31'd0, a_if.pass}, 32'd0);
    check("t5_mismatch", {24'd0, a_if.mismatch}, 32'd0);
    check("t5_busy", {31'd0, a_if.busy}, 32'd0);
    check("t5_gate_in", {29'd0, a_g1, a_g2, a_g3}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'hA8);
    wait_idle();

    // Random gates, codes, start and abort traffic.
    for (int r = 0; r < 6; r++) begin
      gate_tbl_a = 8'($urandom);
      for (int c = 0; c < 60; c++) begin
        drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, 1'b0,
              (r % 2 == 1) ? gate_tbl_a : 8'($urandom));
      end
      wait_idle();
    end

    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
